// File: rtl/inst_disp_sched_pkg.sv
// rtl/inst_disp_sched_pkg.sv - shared defaults, state encoding and blank character
package inst_disp_sched_pkg;

    localparam int NUM_SRC_DEF = 5;
    localparam int STR_LEN_DEF = 19;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/inst_disp_sched_if.sv
// rtl/inst_disp_sched_if.sv - character stream handshake between scheduler and display sink
// Signals:
//   char_valid  scheduler -> sink  character, row and column are valid
//   char_ready  sink -> scheduler  sink accepts the character this cycle
//   char_data   scheduler -> sink  ASCII character
//   char_row    scheduler -> sink  source index
//   char_col    scheduler -> sink  column within the line
interface inst_disp_sched_if;

    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_data;
    logic [2:0] char_row;
    logic [4:0] char_col;

    modport master (
        output char_valid,
        output char_data,
        output char_row,
        output char_col,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_data,
        input  char_row,
        input  char_col,
        output char_ready
    );

endinterface

// File: rtl/inst_line_buf.sv
// rtl/inst_line_buf.sv - line buffer with load, blank-fill and byte left-shift
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load_i     capture a new line (line_i, or all blanks when blank_i)
//   blank_i    fill with blank characters instead of line_i on load
//   shift_i    shift left by one character, zero-filling the LSByte
//   line_i     incoming line, first character in the MSByte
//   msb_o      current first character of the buffer
module inst_line_buf
    import inst_disp_sched_pkg::*;
#(
    parameter int STR_LEN = STR_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 blank_i,
    input  logic                 shift_i,
    input  logic [8*STR_LEN-1:0] line_i,
    output logic [7:0]           msb_o
);

    logic [8*STR_LEN-1:0] buf_q;

    // Load takes priority; the controller never asserts both in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else if (load_i) begin
            buf_q <= blank_i ? {STR_LEN{BLANK_CHAR}} : line_i;
        end else if (shift_i) begin
            buf_q <= {buf_q[8*STR_LEN-9:0], 8'h00};
        end
    end

    assign msb_o = buf_q[8*STR_LEN-1 -: 8];

endmodule

// File: rtl/inst_disp_sched.sv
// rtl/inst_disp_sched.sv - sweeps per-stage instruction words through an external disassembler into a character stream
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   src_code    NUM_SRC packed 32-bit instruction words, source i at [32*i+31:32*i]
//   src_valid   per-source live flag
//   refresh     start one sweep (ignored while busy)
//   dec_code    snapshot word of the current row, to the external disassembler
//   dec_inst    disassembled ASCII line, combinational from dec_code
//   disp        character stream (valid/ready, data, row, column)
//   busy        high whenever a sweep is in progress
//   done        one-cycle pulse when a sweep completes
module inst_disp_sched
    import inst_disp_sched_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int STR_LEN = STR_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*NUM_SRC-1:0] src_code,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic                 refresh,
    output logic [31:0]          dec_code,
    input  logic [8*STR_LEN-1:0] dec_inst,
    inst_disp_sched_if.master    disp,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] ROW_LAST = 3'(NUM_SRC - 1);
    localparam logic [4:0] COL_LAST = 5'(STR_LEN - 1);

    state_e                 state_q, state_d;
    logic [2:0]             row_q, row_d;
    logic [4:0]             col_q, col_d;
    logic [32*NUM_SRC-1:0]  snap_code_q, snap_code_d;
    logic [NUM_SRC-1:0]     snap_valid_q, snap_valid_d;

    logic                   accept;
    logic                   row_blank;
    logic [7:0]             line_msb;

    assign accept = (state_q == ST_SEND) && disp.char_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            snap_code_q  <= '0;
            snap_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            snap_code_q  <= snap_code_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        snap_code_d  = snap_code_q;
        snap_valid_d = snap_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (refresh) begin
                    snap_code_d  = src_code;
                    snap_valid_d = src_valid;
                    row_d        = '0;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                col_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        if (row_q == ROW_LAST) begin
                            state_d = ST_FIN;
                        end else begin
                            row_d   = row_q + 3'd1;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Row select over the snapshot; rows never exceed NUM_SRC-1, so the
    // defaults only matter for unused encodings.
    always_comb begin
        dec_code  = '0;
        row_blank = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (row_q == 3'(i)) begin
                dec_code  = snap_code_q[32*i +: 32];
                row_blank = ~snap_valid_q[i];
            end
        end
    end

    inst_line_buf #(
        .STR_LEN (STR_LEN)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q == ST_LOAD),
        .blank_i (row_blank),
        .shift_i (accept),
        .line_i  (dec_inst),
        .msb_o   (line_msb)
    );

    assign disp.char_valid = (state_q == ST_SEND);
    assign disp.char_data  = line_msb;
    assign disp.char_row   = row_q;
    assign disp.char_col   = col_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_FIN);

endmodule

// File: tb/tb_inst_disp_sched.sv
// tb/tb_inst_disp_sched.sv - randomized self-checking bench for inst_disp_sched
module tb_inst_disp_sched;

    localparam int NUM_SRC = 5;
    localparam int STR_LEN = 19;

    typedef struct {
        int         row;
        int         col;
        logic [7:0] ch;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic [32*NUM_SRC-1:0]  src_code;
    logic [NUM_SRC-1:0]     src_valid;
    logic                   refresh;
    logic [31:0]            dec_code;
    logic [8*STR_LEN-1:0]   dec_inst;
    logic                   busy;
    logic                   done;

    inst_disp_sched_if disp_if ();

    inst_disp_sched #(
        .NUM_SRC (NUM_SRC),
        .STR_LEN (STR_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_code  (src_code),
        .src_valid (src_valid),
        .refresh   (refresh),
        .dec_code  (dec_code),
        .dec_inst  (dec_inst),
        .disp      (disp_if.master),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External disassembler stand-in: two fixed lines, otherwise a
    // deterministic printable scramble of the code word.
    function automatic logic [8*STR_LEN-1:0] disasm(input logic [31:0] code);
        logic [8*STR_LEN-1:0] s;
        if (code == 32'h0000_0013) begin
            s = "nop JStall:addi0   ";
        end else if (code == 32'h0020_81B3) begin
            s = "add x3,x1,x2       ";
        end else begin
            for (int i = 0; i < STR_LEN; i++) begin
                s[8*(STR_LEN-1-i) +: 8] = 8'h41 + 8'((code >> ((i * 3) % 29)) & 32'h1f);
            end
        end
        return s;
    endfunction

    assign dec_inst = disasm(dec_code);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the sweep as a queue of expected characters plus
    // the observable phases (load gap before each line, fin pulse).
    exp_t        q[$];
    logic [31:0] m_snap [NUM_SRC];
    logic [31:0] m_dec;
    bit          m_active, m_gap, m_fin, m_fast;
    int          cyc_n, ref_cyc;
    bit          req_rst, req_refresh;
    int          rdy_mode;
    bit          stall_prev;
    logic [7:0]  prev_data;
    logic [2:0]  prev_row;
    logic [4:0]  prev_col;

    task automatic step();
        bit   exp_valid, rdy, was_active;
        exp_t e;
        logic [8*STR_LEN-1:0] line;
        @(negedge clk);
        cyc_n++;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = ~disp_if.char_ready;
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b0;
        endcase
        disp_if.char_ready = rdy;

        exp_valid = m_active && !m_gap && !m_fin;
        chk("char_valid", 32'(disp_if.char_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_fin));
        if (!m_active) chk("dec_code_idle", dec_code, m_dec);
        if (exp_valid && q.size() > 0) begin
            e = q[0];
            chk("char_data", 32'(disp_if.char_data), 32'(e.ch));
            chk("char_row", 32'(disp_if.char_row), 32'(e.row));
            chk("char_col", 32'(disp_if.char_col), 32'(e.col));
            chk("dec_code", dec_code, m_snap[e.row]);
        end
        if (stall_prev && exp_valid) begin
            chk("stall_data", 32'(disp_if.char_data), 32'(prev_data));
            chk("stall_row", 32'(disp_if.char_row), 32'(prev_row));
            chk("stall_col", 32'(disp_if.char_col), 32'(prev_col));
        end
        if (m_fin && m_fast) chk("sweep_len", 32'(cyc_n - ref_cyc), 32'd101);
        if (exp_valid && !rdy) m_fast = 1'b0;
        stall_prev = exp_valid && !rdy;
        prev_data  = disp_if.char_data;
        prev_row   = disp_if.char_row;
        prev_col   = disp_if.char_col;

        if (req_rst) begin
            m_active   = 1'b0;
            m_gap      = 1'b0;
            m_fin      = 1'b0;
            m_dec      = '0;
            stall_prev = 1'b0;
            q.delete();
            for (int r = 0; r < NUM_SRC; r++) m_snap[r] = '0;
        end else begin
            was_active = m_active;
            if (m_fin) begin
                m_fin    = 1'b0;
                m_active = 1'b0;
                m_dec    = m_snap[NUM_SRC-1];
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (exp_valid && rdy) begin
                e = q.pop_front();
                if (e.col == STR_LEN - 1) begin
                    if (q.size() == 0) m_fin = 1'b1;
                    else               m_gap = 1'b1;
                end
            end
            if (req_refresh && !was_active) begin
                for (int r = 0; r < NUM_SRC; r++) begin
                    m_snap[r] = src_code[32*r +: 32];
                    line = src_valid[r] ? disasm(m_snap[r]) : {STR_LEN{8'h20}};
                    for (int c = 0; c < STR_LEN; c++) begin
                        e.row = r;
                        e.col = c;
                        e.ch  = line[8*(STR_LEN-1-c) +: 8];
                        q.push_back(e);
                    end
                end
                m_active = 1'b1;
                m_gap    = 1'b1;
                m_fast   = (rdy_mode == 0);
                ref_cyc  = cyc_n;
            end
        end
        rst     = req_rst;
        refresh = req_refresh;
    endtask

    task automatic pulse_refresh();
        req_refresh = 1'b1;
        step();
        req_refresh = 1'b0;
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while (m_active && n < bound) begin
            step();
            n++;
        end
        chk("sweep_timeout", 32'(m_active), 32'd0);
    endtask

    task automatic randomize_src();
        for (int r = 0; r < NUM_SRC; r++) src_code[32*r +: 32] = $urandom;
    endtask

    initial begin
        int n;
        rst                = 1'b1;
        refresh            = 1'b0;
        src_code           = '0;
        src_valid          = '0;
        disp_if.char_ready = 1'b0;
        m_active = 1'b0; m_gap = 1'b0; m_fin = 1'b0; m_fast = 1'b0;
        m_dec = '0; cyc_n = 0; ref_cyc = 0; stall_prev = 1'b0;
        for (int r = 0; r < NUM_SRC; r++) m_snap[r] = '0;
        req_rst = 1'b1; req_refresh = 1'b0; rdy_mode = 0;

        // reset state
        repeat (3) step();
        req_rst = 1'b0;
        repeat (2) step();

        // single nop in source 0, full-speed sink, 100-cycle sweep
        src_code[31:0] = 32'h0000_0013;
        src_valid      = 5'b00001;
        rdy_mode       = 0;
        pulse_refresh();
        run_until_idle(500);
        repeat (3) step();

        // add in source 2, sink toggling ready every cycle
        src_code          = '0;
        src_code[95:64]   = 32'h0020_81B3;
        src_valid         = 5'b00100;
        rdy_mode          = 1;
        pulse_refresh();
        run_until_idle(1000);
        rdy_mode = 0;
        step();

        // refresh again mid-sweep is ignored
        randomize_src();
        src_valid = 5'b11111;
        pulse_refresh();
        repeat (9) step();
        pulse_refresh();
        run_until_idle(500);
        step();

        // sources change mid-sweep; emitted line follows the snapshot
        src_code[31:0] = 32'h0000_0013;
        src_valid      = 5'b10101;
        pulse_refresh();
        repeat (30) step();
        randomize_src();
        src_valid = 5'b01010;
        repeat (20) step();
        src_code[31:0] = 32'h0020_81B3;
        run_until_idle(500);
        step();

        // reset at row 1 col 7, then a clean restart
        randomize_src();
        src_valid = 5'b11111;
        rdy_mode  = 2;
        pulse_refresh();
        n = 0;
        while (!(m_active && !m_gap && !m_fin && q.size() > 0 && q[0].row == 1 && q[0].col == 7) && n < 2000) begin
            step();
            n++;
        end
        chk("reach_row1_col7", 32'(n < 2000), 32'd1);
        req_rst = 1'b1;
        step();
        req_rst = 1'b0;
        repeat (3) step();
        rdy_mode = 0;
        pulse_refresh();
        run_until_idle(500);
        step();

        // sink stalled for 50 cycles at row 0 col 0
        src_code[31:0] = 32'h0000_0013;
        src_valid      = 5'b00011;
        pulse_refresh();
        step();
        rdy_mode = 3;
        repeat (50) step();
        rdy_mode = 0;
        run_until_idle(500);
        step();

        // random sweeps with random stalls, source churn and stray refreshes
        for (int s = 0; s < 6; s++) begin
            randomize_src();
            src_valid = 5'($urandom);
            rdy_mode  = 2;
            pulse_refresh();
            n = 0;
            while (m_active && n < 3000) begin
                if ($urandom_range(0, 7) == 0) randomize_src();
                req_refresh = ($urandom_range(0, 15) == 0);
                step();
                n++;
            end
            req_refresh = 1'b0;
            chk("rand_timeout", 32'(m_active), 32'd0);
            repeat (2) step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_disp_sched.md
INST_DISP_SCHED -- requirements
Module: inst_disp_sched

Interface
REQ-001 Parameter NUM_SRC, default 5, number of instruction sources (pipeline stages IF..WB).
REQ-002 Parameter STR_LEN, default 19, characters per decoded line.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 src_code  in  32*NUM_SRC  instruction word per source; source i occupies bits [32*i+31:32*i].
REQ-006 src_valid  in  NUM_SRC  source i holds a live instruction.
REQ-007 refresh  in  1  request one full display sweep.
REQ-008 dec_code  out  32  word driven to the shared external disassembler.
REQ-009 dec_inst  in  8*STR_LEN  ASCII line from the disassembler, combinational from dec_code; first character in the MSByte.
REQ-010 char_valid  out  1  char_data, char_row and char_col are valid.
REQ-011 char_ready  in  1  sink accepts the character this cycle.
REQ-012 char_data  out  8  ASCII character.
REQ-013 char_row  out  3  source index 0..NUM_SRC-1.
REQ-014 char_col  out  5  column 0..STR_LEN-1.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  one-cycle pulse when a sweep completes.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SEND, FIN.
REQ-018 IDLE: when refresh=1, snapshot all src_code and src_valid into registers, set row=0, and go to LOAD; otherwise remain in IDLE.
REQ-019 dec_code SHALL equal snapshot word[row] in every state; it SHALL hold that value in IDLE.
REQ-020 LOAD (exactly 1 cycle): latch dec_inst into the line buffer, or 19 x 8'h20 if snapshot src_valid[row]=0; set col=0; go to SEND.
REQ-021 SEND: char_valid=1 and char_data = line buffer MSByte. On char_valid&char_ready: shift the buffer left 8 bits and increment col.
REQ-022 On acceptance at col=STR_LEN-1: if row<NUM_SRC-1, increment row and go to LOAD; else go to FIN.
REQ-023 FIN (1 cycle): done=1; go to IDLE.
REQ-024 While char_valid=1 and char_ready=0, char_data, char_row and char_col SHALL remain stable.
REQ-025 refresh SHALL be ignored while busy=1; no sweep is queued.
REQ-026 src_code and src_valid changes after the snapshot SHALL NOT affect the sweep in progress.
REQ-027 Timing: with refresh sampled at edge k, the first char_valid is high in the cycle after edge k+1.
REQ-028 With char_ready held at 1, a sweep SHALL take NUM_SRC*(STR_LEN+1) cycles from first LOAD to FIN; 100 cycles at defaults.
REQ-029 char_valid SHALL be 0 in IDLE, LOAD and FIN.

Reset
REQ-030 rst=1 SHALL force IDLE and clear row, col, line buffer, snapshot, char_valid, done and busy to 0, overriding any transition in the same cycle.
REQ-031 A reset during SEND SHALL drop char_valid the cycle after the reset edge, with no further characters and no done pulse.

Structure
REQ-032 A shared package SHALL hold the NUM_SRC and STR_LEN defaults, the state encoding (IDLE/LOAD/SEND/FIN), and BLANK_CHAR=8'h20.
REQ-033 The disassembler SHALL stay outside this block, connected only via dec_code and dec_inst.
REQ-034 One sub-module, inst_line_buf, SHALL implement the 8*STR_LEN-bit load/blank/shift register with an MSByte output.

Verification
REQ-035 src0=32'h00000013, src_valid=5'b00001, char_ready=1, pulse refresh: row 0 cols 0..18 emit "nop JStall:addi0   ", rows 1..4 emit 19 x 8'h20 each, done pulses once, 100 cycles after the first LOAD.
REQ-036 src2=32'h002081B3 (add x3,x1,x2), char_ready toggling 1/0 every cycle: row 2 emits the full decoder line in order, with outputs stable during every stall cycle.
REQ-037 Refresh pulsed again at sweep cycle 10: no restart, and exactly one done pulse.
REQ-038 src_code changed mid-sweep: the emitted characters still match the snapshot values.
REQ-039 rst asserted while row=1 and col=7: char_valid=0 on the next cycle, busy=0, no done pulse; a new refresh then restarts at row 0, col 0.
REQ-040 char_ready=0 for 50 cycles at row 0 col 0: char_valid stays 1 with char_data unchanged, and no columns are skipped after release.
